// File: rtl/uart_rx_framer.sv
// UART receiver front end: 16x oversampled start/data/stop framer
// with a one-entry output buffer and sticky overrun flag.
`timescale 1ns/1ps
module uart_rx_framer #(
   parameter int DBIT     = 8,
   parameter int SB_TICK  = 16,
   parameter int DVSR     = 163,
   parameter int DVSR_BIT = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   input  logic            rd_uart,
   input  logic            clr_err,
   output logic [DBIT-1:0] r_data,
   output logic            rx_empty,
   output logic            frame_err,
   output logic            overrun
);
   localparam int SW = 6;
   localparam int NW = $clog2(DBIT + 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state, state_n;
   logic [SW-1:0]     s, s_n;
   logic [NW-1:0]     n, n_n;
   logic [DBIT-1:0]   b, b_n;
   logic [DVSR_BIT-1:0] cnt;
   logic              sync1, rx_s;
   logic              tick, done, ferr, stop_end;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= rx;
         rx_s  <= sync1;
      end
   end

   assign tick = (cnt == DVSR_BIT'(DVSR - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + DVSR_BIT'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         s     <= '0;
         n     <= '0;
         b     <= '0;
      end else begin
         state <= state_n;
         s     <= s_n;
         n     <= n_n;
         b     <= b_n;
      end
   end

   always_comb begin
      state_n = state;
      s_n     = s;
      n_n     = n;
      b_n     = b;
      unique case (state)
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               s_n     = '0;
            end
         end
         START: begin
            if (tick) begin
               // mid start bit: a high line here was only a glitch
               if (s == SW'(7)) begin
                  if (!rx_s) begin
                     state_n = DATA;
                     s_n     = '0;
                     n_n     = '0;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  s_n = s + SW'(1);
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (s == SW'(15)) begin
                  b_n = {rx_s, b[DBIT-1:1]};
                  s_n = '0;
                  if (n == NW'(DBIT - 1))
                     state_n = STOP;
                  else
                     n_n = n + NW'(1);
               end else begin
                  s_n = s + SW'(1);
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (s == SW'(SB_TICK - 1))
                  state_n = IDLE;
               else
                  s_n = s + SW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      stop_end = (state == STOP) && tick && (s == SW'(SB_TICK - 1));
      done     = stop_end && rx_s;
      ferr     = stop_end && !rx_s;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data    <= '0;
         rx_empty  <= 1'b1;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= ferr;
         if (done) begin
            r_data   <= b;
            rx_empty <= 1'b0;
         end else if (rd_uart && !rx_empty) begin
            rx_empty <= 1'b1;
         end
         // a fresh overwrite takes priority over a clear in the same cycle
         if (done && !rx_empty && !rd_uart)
            overrun <= 1'b1;
         else if (clr_err)
            overrun <= 1'b0;
      end
   end
endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer, DVSR=4.
// One bit = 64 clk.
`timescale 1ns/1ps
module tb_uart_rx_framer;
  localparam int BT = 64;

  logic       clk = 1'b0;
  logic       reset, rx, rd_uart, clr_err;
  logic [7:0] r_data;
  logic       rx_empty, frame_err, overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int lat, t0, ph, fe0;
  logic [7:0] part;

  uart_rx_framer #(
    .DBIT(8), .SB_TICK(16),
    .DVSR(4), .DVSR_BIT(8)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .rd_uart(rd_uart), .clr_err(clr_err),
    .r_data(r_data), .rx_empty(rx_empty),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_err) fe_cnt++;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: obs %0h exp %0h",
             tag, obs, exp);
    end
  endtask

  task automatic send_frame(
    input logic [7:0] d,
    input logic       stp
  );
    rx = 1'b0;
    repeat (BT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BT) @(negedge clk);
    end
    rx = stp;
    repeat (BT) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    reset = 1'b1; rx = 1'b1;
    rd_uart = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", r_data, 8'h00);
    chk("rst_empty", rx_empty, 1'b1);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    t0 = cyc; ph = t0 % 4; lat = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 0; i < 800; i++) begin
          @(negedge clk);
          if (!rx_empty) begin
            lat = cyc - t0;
            break;
          end
        end
      end
    join
    checks++;
    if (lat < 0) begin
      errors++;
      $error("FAIL t1_timeout: no byte");
    end
    chk("t1_latency",
        (lat >= 600 && lat <= 616), 1'b1);
    chk("t1_rdata", r_data, 8'hA5);
    chk("t1_empty", rx_empty, 1'b0);
    chk("t1_ferr_cnt", fe_cnt, 0);
    chk("t1_ovr", overrun, 1'b0);
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
    chk("t1_pop_empty", rx_empty, 1'b1);
    chk("t1_pop_rdata", r_data, 8'hA5);

    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (700) @(negedge clk);
    chk("t2_empty", rx_empty, 1'b1);
    chk("t2_ferr_cnt", fe_cnt, 0);

    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    chk("t3_ferr_pulse", fe_cnt - fe0, 1);
    chk("t3_empty", rx_empty, 1'b1);
    chk("t3_rdata", r_data, 8'hA5);
    chk("t3_ovr", overrun, 1'b0);
    fe0 = fe_cnt;

    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (40) @(negedge clk);
    chk("t4_rdata", r_data, 8'h22);
    chk("t4_empty", rx_empty, 1'b0);
    chk("t4_ovr", overrun, 1'b1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("t4_clr_ovr", overrun, 1'b0);
    chk("t4_clr_rdata", r_data, 8'h22);
    chk("t4_clr_empty", rx_empty, 1'b0);

    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
    chk("t5_pop_empty", rx_empty, 1'b1);
    send_frame(8'h11, 1'b1);
    repeat (10) @(negedge clk);
    chk("t5_first_rdata", r_data, 8'h11);
    chk("t5_first_empty", rx_empty, 1'b0);
    for (int i = 0; i < 8 && (cyc % 4) != ph; i++)
      @(negedge clk);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (lat - 1) @(negedge clk);
        rd_uart = 1'b1;
        @(negedge clk);
        rd_uart = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    chk("t5_rdata", r_data, 8'h22);
    chk("t5_empty", rx_empty, 1'b0);
    chk("t5_ovr", overrun, 1'b0);

    send_frame(8'h33, 1'b1);
    repeat (10) @(negedge clk);
    chk("t6_pre_ovr", overrun, 1'b1);
    part = 8'h5A;
    rx = 1'b0;
    repeat (BT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = part[i];
      repeat (BT) @(negedge clk);
    end
    reset = 1'b1;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_rst_rdata", r_data, 8'h00);
    chk("t6_rst_empty", rx_empty, 1'b1);
    chk("t6_rst_ovr", overrun, 1'b0);
    chk("t6_rst_ferr", frame_err, 1'b0);
    reset = 1'b0;
    repeat (700) @(negedge clk);
    chk("t6_idle_empty", rx_empty, 1'b1);
    send_frame(8'h96, 1'b1);
    repeat (10) @(negedge clk);
    chk("t6_rdata", r_data, 8'h96);
    chk("t6_empty", rx_empty, 1'b0);
    chk("t6_ovr", overrun, 1'b0);
    chk("t6_ferr_cnt", fe_cnt, fe0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
